// File: rtl/bp_clint_slave_if.sv
// Command/response bus between the uncached memory-command router and the CLINT.
// Signal names carry the direction as seen from the CLINT (slave) side.
interface bp_clint_slave_if #(
    parameter int unsigned paddr_width_p = 40
);
    logic                     cmd_v_i;
    logic                     cmd_ready_o;
    logic                     cmd_we_i;
    logic [paddr_width_p-1:0] cmd_addr_i;
    logic [1:0]               cmd_size_i;
    logic [63:0]              cmd_data_i;
    logic                     resp_v_o;
    logic                     resp_yumi_i;
    logic [63:0]              resp_data_o;

    modport slave (
        input  cmd_v_i,
        input  cmd_we_i,
        input  cmd_addr_i,
        input  cmd_size_i,
        input  cmd_data_i,
        input  resp_yumi_i,
        output cmd_ready_o,
        output resp_v_o,
        output resp_data_o
    );

    modport master (
        output cmd_v_i,
        output cmd_we_i,
        output cmd_addr_i,
        output cmd_size_i,
        output cmd_data_i,
        output resp_yumi_i,
        input  cmd_ready_o,
        input  resp_v_o,
        input  resp_data_o
    );
endinterface

// File: rtl/bp_clint_slave.sv
// CLINT target: per-core mipi/mtimecmp/plic registers, shared mtime, one command in flight.
// Optional BP_CLINT_PRESCALER_EN derives the mtime tick from the clock instead of rtc_tick_i.
module bp_clint_slave #(
    parameter int unsigned num_core_p    = 1,
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned mtime_div_p   = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rtc_tick_i,
    bp_clint_slave_if.slave       bus,
    output logic [num_core_p-1:0] software_irq_o,
    output logic [num_core_p-1:0] timer_irq_o,
    output logic [num_core_p-1:0] external_irq_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StResp = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [63:0]           resp_data_q, resp_data_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q [num_core_p];
    logic [63:0]           mtimecmp_d [num_core_p];
    logic [num_core_p-1:0] mipi_q, mipi_d;
    logic [num_core_p-1:0] plic_q, plic_d;

    logic        accept;
    logic        do_write;
    logic        mtime_tick;
    logic [19:0] reg_addr;
    logic        region_hit;
    logic        hit_mipi, hit_cmp, hit_plic, hit_mtime;
    logic        wide_reg;
    logic [3:0]  idx_word, idx_dword;
    logic [2:0]  off;
    logic [3:0]  nbytes;
    logic        aligned;
    logic        valid_access;
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] wdata_sh;
    logic [63:0] cur_val;
    logic [63:0] merged;
    logic [63:0] size_mask;
    logic [63:0] rdata;

    assign bus.cmd_ready_o = (state_q == StIdle) && !reset_i;
    assign bus.resp_v_o    = (state_q == StResp);
    assign bus.resp_data_o = resp_data_q;

    assign accept   = bus.cmd_v_i && bus.cmd_ready_o;
    assign reg_addr = bus.cmd_addr_i[19:0];
    assign idx_word  = reg_addr[5:2];
    assign idx_dword = reg_addr[6:3];

    // Address decode: each window admits only indices below num_core_p.
    assign region_hit = (bus.cmd_addr_i[paddr_width_p-1:20] == (paddr_width_p-20)'(3));
    assign hit_mipi   = region_hit && (reg_addr[19:6] == 14'h000)
                        && ({28'd0, idx_word} < num_core_p);
    assign hit_cmp    = region_hit && (reg_addr[19:7] == 13'h080)
                        && ({28'd0, idx_dword} < num_core_p);
    assign hit_plic   = region_hit && (reg_addr[19:6] == 14'h2c0)
                        && ({28'd0, idx_word} < num_core_p);
    assign hit_mtime  = region_hit && (reg_addr[19:3] == 17'h17ff);

    assign wide_reg = hit_cmp || hit_mtime;
    assign off      = wide_reg ? reg_addr[2:0] : {1'b0, reg_addr[1:0]};
    assign nbytes   = 4'd1 << bus.cmd_size_i;

    // Natural alignment, and the access must stay inside the 4B or 8B register.
    assign aligned = (({1'b0, off} & (nbytes - 4'd1)) == 4'd0)
                     && (({1'b0, off} + nbytes) <= (wide_reg ? 4'd8 : 4'd4));
    assign valid_access = (hit_mipi || hit_cmp || hit_plic || hit_mtime) && aligned;
    assign do_write     = accept && bus.cmd_we_i && valid_access;

    assign byte_mask = ((8'd1 << nbytes) - 8'd1) << off;
    assign wdata_sh  = bus.cmd_data_i << {off, 3'b000};

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
    end

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < int'(num_core_p); i++) begin
            if (hit_mipi && (idx_word == 4'(i))) begin
                cur_val = {63'd0, mipi_q[i]};
            end
            if (hit_plic && (idx_word == 4'(i))) begin
                cur_val = {63'd0, plic_q[i]};
            end
            if (hit_cmp && (idx_dword == 4'(i))) begin
                cur_val = mtimecmp_q[i];
            end
        end
        if (hit_mtime) begin
            cur_val = mtime_q;
        end
    end

    assign merged = (cur_val & ~bit_mask) | (wdata_sh & bit_mask);

    always_comb begin
        unique case (bus.cmd_size_i)
            2'd0:    size_mask = 64'h0000_0000_0000_00ff;
            2'd1:    size_mask = 64'h0000_0000_0000_ffff;
            2'd2:    size_mask = 64'h0000_0000_ffff_ffff;
            default: size_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    end

    assign rdata = (cur_val >> {off, 3'b000}) & size_mask;

`ifdef BP_CLINT_PRESCALER_EN
    localparam int unsigned div_width_lp = (mtime_div_p > 1) ? $clog2(mtime_div_p) : 1;

    logic [div_width_lp-1:0] div_cnt_q, div_cnt_d;
    logic                    unused_rtc;

    assign unused_rtc = rtc_tick_i;
    assign mtime_tick = (div_cnt_q == div_width_lp'(mtime_div_p - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (mtime_tick || (do_write && hit_mtime)) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    logic unused_div;

    assign unused_div = ^mtime_div_p;
    assign mtime_tick = rtc_tick_i;
`endif

    // A write to mtime overrides that cycle's increment.
    always_comb begin
        mtime_d = mtime_q;
        if (do_write && hit_mtime) begin
            mtime_d = merged;
        end else if (mtime_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        mipi_d     = mipi_q;
        plic_d     = plic_q;
        mtimecmp_d = mtimecmp_q;
        for (int i = 0; i < int'(num_core_p); i++) begin
            if (do_write && hit_mipi && (idx_word == 4'(i))) begin
                mipi_d[i] = merged[0];
            end
            if (do_write && hit_plic && (idx_word == 4'(i))) begin
                plic_d[i] = merged[0];
            end
            if (do_write && hit_cmp && (idx_dword == 4'(i))) begin
                mtimecmp_d[i] = merged;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StResp;
                    resp_data_d = (!bus.cmd_we_i && valid_access) ? rdata : 64'd0;
                end
            end
            default: begin
                if (bus.resp_yumi_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            resp_data_q <= '0;
            mtime_q     <= '0;
            mipi_q      <= '0;
            plic_q      <= '0;
            for (int i = 0; i < int'(num_core_p); i++) begin
                mtimecmp_q[i] <= '1;
            end
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            mtime_q     <= mtime_d;
            mipi_q      <= mipi_d;
            plic_q      <= plic_d;
            for (int i = 0; i < int'(num_core_p); i++) begin
                mtimecmp_q[i] <= mtimecmp_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(num_core_p); i++) begin
            software_irq_o[i] = mipi_q[i];
            external_irq_o[i] = plic_q[i];
            timer_irq_o[i]    = (mtime_q >= mtimecmp_q[i]);
        end
    end

endmodule

// File: tb/tb_bp_clint_slave.sv
// Self-checking bench for bp_clint_slave: directed scenarios plus random traffic
// checked against a byte-level register model.
module tb_bp_clint_slave;

    localparam int NC = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rtc_tick;
    logic [NC-1:0] sw_irq;
    logic [NC-1:0] tm_irq;
    logic [NC-1:0] ex_irq;

    bp_clint_slave_if #(.paddr_width_p(40)) bus ();

    bp_clint_slave #(
        .num_core_p   (NC),
        .paddr_width_p(40),
        .mtime_div_p  (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rtc_tick_i    (rtc_tick),
        .bus           (bus),
        .software_irq_o(sw_irq),
        .timer_irq_o   (tm_irq),
        .external_irq_o(ex_irq)
    );

    always #5 clk = ~clk;

    // Reference model state.
    longint unsigned m_mtime;
    longint unsigned m_cmp [NC];
    bit              m_mipi[NC];
    bit              m_plic[NC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mtime = 0;
        for (int i = 0; i < NC; i++) begin
            m_cmp[i]  = 64'hffff_ffff_ffff_ffff;
            m_mipi[i] = 1'b0;
            m_plic[i] = 1'b0;
        end
    endfunction

    // Returns read data (0 for writes/illegal) and applies any write to the model.
    function automatic logic [63:0] model_access(input bit we, input logic [39:0] addr,
                                                 input logic [1:0] size, input logic [63:0] data,
                                                 output bit mtime_wr);
        int          kind, idx, width, off, n, a;
        logic [63:0] val, r;
        mtime_wr = 1'b0;
        kind = 0; idx = 0; width = 0; off = 0;
        if (addr[39:20] == 20'h00003) begin
            a = int'(addr[19:0]);
            if (a < 4*NC) begin
                kind = 1; idx = a / 4; width = 4; off = a % 4;
            end else if (a >= 'h4000 && a < 'h4000 + 8*NC) begin
                kind = 2; idx = (a - 'h4000) / 8; width = 8; off = (a - 'h4000) % 8;
            end else if (a >= 'hb000 && a < 'hb000 + 4*NC) begin
                kind = 3; idx = (a - 'hb000) / 4; width = 4; off = (a - 'hb000) % 4;
            end else if (a >= 'hbff8 && a < 'hc000) begin
                kind = 4; width = 8; off = a - 'hbff8;
            end
        end
        n = 1 << size;
        if (kind == 0 || (off % n) != 0 || off + n > width) return 64'd0;
        case (kind)
            1:       val = 64'(m_mipi[idx]);
            2:       val = m_cmp[idx];
            3:       val = 64'(m_plic[idx]);
            default: val = m_mtime;
        endcase
        if (we) begin
            for (int k = 0; k < n; k++) val[8*(off+k) +: 8] = data[8*k +: 8];
            case (kind)
                1:       m_mipi[idx] = val[0];
                2:       m_cmp[idx]  = val;
                3:       m_plic[idx] = val[0];
                default: m_mtime     = val;
            endcase
            mtime_wr = (kind == 4);
            return 64'd0;
        end
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = val[8*(off+k) +: 8];
        return r;
    endfunction

    task automatic cycle(input bit t, input bit suppress);
        rtc_tick = t;
        if (t && !suppress) m_mtime++;
        @(posedge clk);
        #1;
        rtc_tick = 1'b0;
    endtask

    task automatic check_irqs(input string tag);
        logic [NC-1:0] e_sw, e_tm, e_ex;
        for (int i = 0; i < NC; i++) begin
            e_sw[i] = m_mipi[i];
            e_ex[i] = m_plic[i];
            e_tm[i] = (m_mtime >= m_cmp[i]);
        end
        check_val({tag, ".sw_irq"}, 64'(sw_irq), 64'(e_sw));
        check_val({tag, ".timer_irq"}, 64'(tm_irq), 64'(e_tm));
        check_val({tag, ".ext_irq"}, 64'(ex_irq), 64'(e_ex));
    endtask

    // tick_mode: 0 no ticks, 1 tick only on the accept cycle, 2 random ticks throughout.
    task automatic do_cmd(input bit we, input logic [39:0] addr, input logic [1:0] size,
                          input logic [63:0] data, input int tick_mode, input int hold,
                          output logic [63:0] rd);
        bit          mw;
        bit          t;
        logic [63:0] exp;
        check_val("cmd_ready_idle", 64'(bus.cmd_ready_o), 64'd1);
        bus.cmd_v_i    = 1'b1;
        bus.cmd_we_i   = we;
        bus.cmd_addr_i = addr;
        bus.cmd_size_i = size;
        bus.cmd_data_i = data;
        exp = model_access(we, addr, size, data, mw);
        t = (tick_mode == 1) ? 1'b1 : (tick_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        cycle(t, mw);
        bus.cmd_v_i    = 1'b0;
        bus.cmd_addr_i = {$urandom, $urandom};
        bus.cmd_data_i = {$urandom, $urandom};
        check_irqs("post_accept");
        for (int h = 0; h < hold; h++) begin
            cycle((tick_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        end
        check_val("resp_v", 64'(bus.resp_v_o), 64'd1);
        check_val("cmd_ready_busy", 64'(bus.cmd_ready_o), 64'd0);
        check_val("resp_data", bus.resp_data_o, exp);
        rd = bus.resp_data_o;
        bus.resp_yumi_i = 1'b1;
        cycle((tick_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        bus.resp_yumi_i = 1'b0;
        check_val("resp_v_after_yumi", 64'(bus.resp_v_o), 64'd0);
    endtask

    logic [63:0] rd;
    logic [39:0] raddr;
    logic [63:0] held;

    initial begin
        reset           = 1'b1;
        rtc_tick        = 1'b0;
        bus.cmd_v_i     = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_addr_i  = 40'h00_0030_0000;
        bus.cmd_size_i  = 2'd2;
        bus.cmd_data_i  = 64'd1;
        bus.resp_yumi_i = 1'b0;
        model_reset();
        cycle(0, 0);
        cycle(0, 0);
        check_val("reset_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        check_val("reset_resp_v", 64'(bus.resp_v_o), 64'd0);
        check_val("reset_resp_data", bus.resp_data_o, 64'd0);
        check_irqs("reset");
        reset       = 1'b0;
        bus.cmd_v_i = 1'b0;
        cycle(0, 0);
        check_val("no_accept_in_reset", 64'(bus.resp_v_o), 64'd0);
        check_irqs("after_reset");

        do_cmd(0, 40'h00_0030_4000, 2'd3, 64'd0, 0, 0, rd);
        check_val("mtimecmp_reset", rd, 64'hffff_ffff_ffff_ffff);

        do_cmd(1, 40'h00_0030_0000, 2'd2, 64'd1, 0, 0, rd);
        check_val("mipi_set", 64'(sw_irq[0]), 64'd1);
        do_cmd(0, 40'h00_0030_0000, 2'd2, 64'd0, 0, 1, rd);
        check_val("mipi_read", rd, 64'd1);
        do_cmd(1, 40'h00_0030_0000, 2'd2, 64'd0, 0, 0, rd);
        check_val("mipi_clear", 64'(sw_irq[0]), 64'd0);

        do_cmd(1, 40'h00_0030_b000, 2'd0, 64'hff, 0, 0, rd);
        check_val("plic_set", 64'(ex_irq[0]), 64'd1);

        do_cmd(1, 40'h00_0030_4000, 2'd3, 64'd5, 0, 0, rd);
        do_cmd(1, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd);
        for (int k = 1; k <= 5; k++) begin
            cycle(1, 0);
            check_irqs("tick_run");
        end
        check_val("timer_rise", 64'(tm_irq[0]), 64'd1);
        do_cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd);
        check_val("mtime_5", rd, 64'd5);

        do_cmd(1, 40'h00_0030_bff8, 2'd3, 64'hffff_ffff_ffff_ffff, 1, 0, rd);
        do_cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd);
        check_val("mtime_write_wins", rd, 64'hffff_ffff_ffff_ffff);
        cycle(1, 0);
        check_val("timer_drop_wrap", 64'(tm_irq[0]), 64'd0);
        do_cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd);
        check_val("mtime_wrap", rd, 64'd0);

        do_cmd(1, 40'h00_0030_bff8, 2'd3, 64'h0123_4567_89ab_cdef, 0, 0, rd);
        do_cmd(1, 40'h00_0030_bffc, 2'd2, 64'hdead_beef, 0, 0, rd);
        do_cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd);
        check_val("mtime_partial", rd, 64'hdead_beef_89ab_cdef);
        do_cmd(0, 40'h00_0030_bff9, 2'd1, 64'd0, 0, 0, rd);
        check_val("misaligned_read", rd, 64'd0);

        // Unmapped read with a stalled consumer, then reset while the response is pending.
        bus.cmd_v_i    = 1'b1;
        bus.cmd_we_i   = 1'b0;
        bus.cmd_addr_i = 40'h00_0030_4008;
        bus.cmd_size_i = 2'd3;
        cycle(0, 0);
        bus.cmd_v_i = 1'b0;
        held = bus.resp_data_o;
        check_val("unmapped_read", held, 64'd0);
        for (int k = 0; k < 10; k++) begin
            check_val("stall_resp_v", 64'(bus.resp_v_o), 64'd1);
            check_val("stall_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
            check_val("stall_data", bus.resp_data_o, 64'd0);
            cycle(0, 0);
        end
        reset       = 1'b1;
        bus.cmd_v_i = 1'b1;
        cycle(0, 0);
        model_reset();
        check_val("reset_drops_resp", 64'(bus.resp_v_o), 64'd0);
        check_val("reset_ready_low", 64'(bus.cmd_ready_o), 64'd0);
        cycle(0, 0);
        reset       = 1'b0;
        bus.cmd_v_i = 1'b0;
        cycle(0, 0);
        check_val("no_resp_after_reset", 64'(bus.resp_v_o), 64'd0);
        check_irqs("after_mid_reset");
        do_cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd);
        check_val("mtime_after_reset", rd, 64'd0);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 6))
                0:       raddr = 40'h00_0030_0000 + 40'($urandom_range(0, 7));
                1:       raddr = 40'h00_0030_4000 + 40'($urandom_range(0, 15));
                2:       raddr = 40'h00_0030_b000 + 40'($urandom_range(0, 7));
                3:       raddr = 40'h00_0030_bff8 + 40'($urandom_range(0, 7));
                4:       raddr = 40'h00_0030_bff0 + 40'($urandom_range(0, 7));
                5:       raddr = 40'h01_0030_4000 + 40'($urandom_range(0, 7));
                default: raddr = {8'($urandom), $urandom};
            endcase
            do_cmd(1'($urandom_range(0, 1)), raddr, 2'($urandom_range(0, 3)),
                   {$urandom, $urandom}, 2, $urandom_range(0, 3), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_clint_slave.md
Name: bp_clint_slave

Overview:
- Core-local interruptor device: the memory-mapped target that consumes commands routed to the CLINT region at 0x0030_0000.
- Holds the per-core software-interrupt (mipi), timer-compare (mtimecmp) and external-interrupt (plic) registers, plus one shared mtime counter.
- Drives the software, timer and external interrupt lines into each core.
- Sits downstream of the uncached memory-command router, with one outstanding command at a time.

Parameters:
- num_core_p, 1, number of harts served (1..16).
- paddr_width_p, 40, physical address width of the command address.
- mtime_div_p, 8, clock cycles per mtime increment; used only when BP_CLINT_PRESCALER_EN is defined.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-high.
- rtc_tick_i  in  1  real-time tick; mtime +1 on each cycle it is high.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  paddr_width_p  byte address.
- cmd_size_i  in  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
- cmd_data_i  in  64  write data, right-aligned.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  consumer takes the response; legal only while resp_v_o=1.
- resp_data_o  out  64  read data, right-aligned and zero-extended; 0 for writes.
- software_irq_o  out  num_core_p  mipi[i] bit 0.
- timer_irq_o  out  num_core_p  (mtime >= mtimecmp[i]), unsigned 64-bit compare.
- external_irq_o  out  num_core_p  plic[i] bit 0.

Behaviour:
- Reset values: mtime=0; every mtimecmp=all ones; mipi=0; plic=0; resp_v_o=0; resp_data_o=0; cmd_ready_o=0 while reset_i=1. All irq outputs are 0 after reset.
- FSM has two states.
  - IDLE: cmd_ready_o=1. On accept, decode, perform the write or capture the read data, then go to RESP.
  - RESP: cmd_ready_o=0, resp_v_o=1, resp_data_o held stable. On resp_yumi_i go to IDLE.
  - Minimum turnaround is 2 cycles per command (no accept in the same cycle as yumi).
- Region hit: cmd_addr_i[paddr_width_p-1:20] == 0x003.
- Register map; i must be < num_core_p, otherwise the address is unmapped:
  - mipi[i] at 0x0030_0000 + 4*i; 4B register, only bit 0 stored, other bits read 0.
  - mtimecmp[i] at 0x0030_4000 + 8*i; 64-bit.
  - plic[i] at 0x0030_b000 + 4*i; bit 0 only.
  - mtime at 0x0030_bff8; 64-bit.
- Sub-word access:
  - Byte offset off = addr[2:0] (addr[1:0] for 4B registers).
  - Writes update only bytes off .. off+2^size-1, taken from cmd_data_i low bytes.
  - Reads return register >> (8*off), masked to 2^size bytes.
- Misaligned access (off not a multiple of 2^size, or crosses the register width): write dropped, read returns 0. A response is still produced.
- Unmapped or out-of-region address: write dropped, read returns 0, response still produced.
- mtime increments by 1 per rtc_tick_i cycle and wraps from 2^64-1 to 0.
  - A write to mtime in the same cycle as a tick wins; the tick is lost.
  - A partial write updates only its bytes and does not carry into other bytes.
- Reads of mtime capture the value before that cycle's increment.
- timer_irq_o is combinational from the registers. It updates the cycle after an mtime or mtimecmp change.
- reset_i asserted while in RESP drops the pending response; the FSM returns to IDLE, and all registers take their reset values.
- A command presented during reset is not accepted.

Optional Feature:
- Macro BP_CLINT_PRESCALER_EN.
- Defined:
  - rtc_tick_i is ignored.
  - An internal counter of width clog2(mtime_div_p) counts 0..mtime_div_p-1.
  - mtime increments when the counter wraps; the counter resets to 0.
  - A write to mtime also clears the counter.
- Undefined: no prescaler logic; mtime is driven only by rtc_tick_i.

Test Plan:
- Reset, then read 8B at 0x0030_4000 -> resp_data_o=0xFFFF_FFFF_FFFF_FFFF; timer_irq_o=0, software_irq_o=0.
- Write 4B 0x1 to 0x0030_0000, then yumi -> software_irq_o[0]=1 the cycle after accept; read back returns 0x1. Write 0x0 -> software_irq_o[0]=0.
- Write mtimecmp[0]=5, write mtime=0, pulse rtc_tick_i 5 times -> timer_irq_o[0] rises the cycle after the 5th tick; read mtime returns 5.
- Write mtime=0xFFFF_FFFF_FFFF_FFFF with rtc_tick_i high in the same cycle -> mtime = all ones. Next tick -> mtime=0 and timer_irq_o[0] drops if mtimecmp[0]=5.
- 4B write 0xDEAD_BEEF at 0x0030_bffc, then 8B read at 0x0030_bff8 -> upper half 0xDEAD_BEEF, lower half unchanged. 2B read at 0x0030_bff9 (misaligned) -> 0.
- Read 0x0030_4008 with num_core_p=1 -> data 0. Hold resp_yumi_i low 10 cycles -> resp_v_o stays 1, data stable, cmd_ready_o=0. Assert reset_i in RESP -> resp_v_o=0 next cycle.
